// File: rtl/operand_stack_pkg.sv
// operand_stack_pkg: op codes and trap codes shared by the operand stack and the cpu core.
//   op_e   - 3-bit operation code presented on operand_stack.op
//   trap_e - 3-bit sticky trap code reported on operand_stack.trap
package operand_stack_pkg;

  typedef enum logic [2:0] {
    OpNop    = 3'd0,
    OpPush   = 3'd1,
    OpPop    = 3'd2,
    OpSetTop = 3'd3,  // replace top (unary result)
    OpPopSet = 3'd4,  // drop top, replace new top (binary result)
    OpClear  = 3'd7   // codes 5 and 6 are illegal
  } op_e;

  typedef enum logic [2:0] {
    TrapNone      = 3'd0,
    TrapOverflow  = 3'd1,
    TrapUnderflow = 3'd2,
    TrapIllegal   = 3'd3
  } trap_e;

endpackage

// File: rtl/stack_mem.sv
// stack_mem: DEPTH x WIDTH register array holding the stack entries.
//   clk_i          - clock
//   we_i / waddr_i / wdata_i    - single write port
//   raddr_top_i / rdata_top_o   - asynchronous read port for the top entry
//   raddr_sec_i / rdata_sec_o   - asynchronous read port for the entry below top
// Contents are not reset.
module stack_mem #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_top_i,
  output logic [WIDTH-1:0] rdata_top_o,
  input  logic [AW-1:0]    raddr_sec_i,
  output logic [WIDTH-1:0] rdata_sec_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_top_o = mem_q[raddr_top_i];
  assign rdata_sec_o = mem_q[raddr_sec_i];

endmodule

// File: rtl/operand_stack.sv
// operand_stack: operand stack with registered top/second views and a sticky trap.
//   clk          - clock, all state changes on its rising edge
//   reset        - synchronous active-high reset
//   op, valid    - operation request; accepted when valid && ready
//   ready        - high while no trap is pending
//   din          - operand for PUSH / SET_TOP / POP_SET
//   result       - registered top of stack (0 when empty)
//   result_empty - high when depth is 0
//   second       - registered entry below top (0 when depth < 2)
//   depth        - entry count, 0..DEPTH
//   trap         - sticky trap code, cleared only by reset
module operand_stack
  import operand_stack_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned DW   = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       op,
  input  logic             valid,
  output logic             ready,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] result,
  output logic             result_empty,
  output logic [WIDTH-1:0] second,
  output logic [DW-1:0]    depth,
  output logic [2:0]       trap
);

  logic [DW-1:0]    depth_q, depth_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] second_q, second_d;
  logic [2:0]       trap_q, trap_d;

  logic             accept;
  logic             mem_we;
  logic [AW-1:0]    top_addr;
  logic [AW-1:0]    sec_addr;
  logic [WIDTH-1:0] rd_top;
  logic [WIDTH-1:0] rd_sec;

  assign ready  = (trap_q == TrapNone);
  assign accept = valid && ready;

  // Next depth and trap; every write targets the post-op top slot.
  always_comb begin
    depth_d = depth_q;
    trap_d  = trap_q;
    mem_we  = 1'b0;
    if (accept) begin
      case (op_e'(op))
        OpNop: ;
        OpPush: begin
          if (depth_q == DW'(DEPTH)) begin
            trap_d = TrapOverflow;
          end else begin
            depth_d = depth_q + DW'(1);
            mem_we  = 1'b1;
          end
        end
        OpPop: begin
          if (depth_q == '0) begin
            trap_d = TrapUnderflow;
          end else begin
            depth_d = depth_q - DW'(1);
          end
        end
        OpSetTop: begin
          if (depth_q == '0) begin
            trap_d = TrapUnderflow;
          end else begin
            mem_we = 1'b1;
          end
        end
        OpPopSet: begin
          if (depth_q < DW'(2)) begin
            trap_d = TrapUnderflow;
          end else begin
            depth_d = depth_q - DW'(1);
            mem_we  = 1'b1;
          end
        end
        OpClear: depth_d = '0;
        default: trap_d = TrapIllegal;
      endcase
    end
  end

  // Read the post-op top and top-1; only the top slot can be written this cycle, so only it
  // needs a bypass from din. Out-of-range addresses are masked by the depth checks below.
  always_comb begin
    top_addr = AW'(depth_d - DW'(1));
    sec_addr = AW'(depth_d - DW'(2));
    result_d = '0;
    second_d = '0;
    if (depth_d != '0) begin
      result_d = mem_we ? din : rd_top;
    end
    if (depth_d >= DW'(2)) begin
      second_d = rd_sec;
    end
  end

  stack_mem #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_stack_mem (
    .clk_i       (clk),
    .we_i        (mem_we),
    .waddr_i     (top_addr),
    .wdata_i     (din),
    .raddr_top_i (top_addr),
    .rdata_top_o (rd_top),
    .raddr_sec_i (sec_addr),
    .rdata_sec_o (rd_sec)
  );

  // Reset dominates: a simultaneous op is discarded (the stray entry write is harmless).
  always_ff @(posedge clk) begin
    if (reset) begin
      depth_q  <= '0;
      result_q <= '0;
      second_q <= '0;
      trap_q   <= TrapNone;
    end else begin
      depth_q  <= depth_d;
      result_q <= result_d;
      second_q <= second_d;
      trap_q   <= trap_d;
    end
  end

  assign result       = result_q;
  assign second       = second_q;
  assign depth        = depth_q;
  assign trap         = trap_q;
  assign result_empty = (depth_q == '0);

endmodule

// File: tb/tb_operand_stack.sv
// tb_operand_stack: directed bench for operand_stack (WIDTH=32, DEPTH=4) with a queue-based
// reference model compared every cycle, plus hand-computed literal checks.
module tb_operand_stack;

  localparam int unsigned W  = 32;
  localparam int unsigned D  = 4;
  localparam int unsigned DW = $clog2(D) + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [2:0]    op;
  logic          valid;
  logic          ready;
  logic [W-1:0]  din;
  logic [W-1:0]  result;
  logic          result_empty;
  logic [W-1:0]  second;
  logic [DW-1:0] depth;
  logic [2:0]    trap;

  operand_stack #(
    .WIDTH(W),
    .DEPTH(D)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .op           (op),
    .valid        (valid),
    .ready        (ready),
    .din          (din),
    .result       (result),
    .result_empty (result_empty),
    .second       (second),
    .depth        (depth),
    .trap         (trap)
  );

  always #5 clk = ~clk;

  // Reference model: the stack as a queue, back = top.
  logic [W-1:0] mq[$];
  int           mtrap    = 0;
  bit           checking = 1'b0;
  int           errors   = 0;
  int           checks   = 0;

  function automatic logic [W-1:0] m_result();
    return (mq.size() > 0) ? mq[mq.size()-1] : '0;
  endfunction

  function automatic logic [W-1:0] m_second();
    return (mq.size() > 1) ? mq[mq.size()-2] : '0;
  endfunction

  task automatic model_step(input logic r, input logic v, input logic [2:0] o,
                            input logic [W-1:0] d);
    if (r) begin
      mq.delete();
      mtrap = 0;
    end else if (v && mtrap == 0) begin
      case (o)
        3'd0: ;
        3'd1: if (mq.size() == D) mtrap = 1; else mq.push_back(d);
        3'd2: if (mq.size() == 0) mtrap = 2; else void'(mq.pop_back());
        3'd3: if (mq.size() == 0) mtrap = 2; else mq[mq.size()-1] = d;
        3'd4: begin
          if (mq.size() < 2) mtrap = 2;
          else begin
            void'(mq.pop_back());
            mq[mq.size()-1] = d;
          end
        end
        3'd7: mq.delete();
        default: mtrap = 3;
      endcase
    end
  endtask

  task automatic cyc(input logic r, input logic v, input logic [2:0] o, input logic [W-1:0] d);
    reset = r;
    valid = v;
    op    = o;
    din   = d;
    @(posedge clk);
    model_step(r, v, o, d);
    if (r) checking = 1'b1;
    #1;
    reset = 1'b0;
    valid = 1'b0;
    op    = 3'd0;
  endtask

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (checking) begin
      check("cyc_result", result, m_result());
      check("cyc_second", second, m_second());
      check("cyc_depth", W'(depth), W'(mq.size()));
      check("cyc_empty", W'(result_empty), W'(mq.size() == 0));
      check("cyc_trap", W'(trap), W'(mtrap));
      check("cyc_ready", W'(ready), W'(mtrap == 0));
    end
  end

  initial begin
    reset = 1'b0;
    valid = 1'b0;
    op    = 3'd0;
    din   = '0;

    // Reset state
    cyc(1, 0, 0, 0);
    check("rst_depth", W'(depth), 0);
    check("rst_result", result, 0);
    check("rst_empty", W'(result_empty), 1);
    check("rst_ready", W'(ready), 1);

    // eqz case: PUSH 0, SET_TOP 1 back to back
    cyc(0, 1, 1, 0);
    cyc(0, 1, 3, 1);
    check("eqz_result", result, 1);
    check("eqz_empty", W'(result_empty), 0);
    check("eqz_depth", W'(depth), 1);
    check("eqz_trap", W'(trap), 0);

    // PUSH 5, PUSH 7, POP_SET 12
    cyc(1, 0, 0, 0);
    cyc(0, 1, 1, 5);
    cyc(0, 1, 1, 7);
    check("push2_second", second, 5);
    cyc(0, 1, 4, 12);
    check("popset_result", result, 12);
    check("popset_depth", W'(depth), 1);
    check("popset_second", second, 0);

    // valid low holds state; then a 3-deep stack with POP
    cyc(0, 0, 1, 99);
    check("hold_depth", W'(depth), 1);
    cyc(0, 1, 1, 20);
    cyc(0, 1, 1, 30);
    cyc(0, 1, 2, 0);
    check("pop_result", result, 20);
    check("pop_second", second, 12);

    // Overflow with DEPTH=4, then POP ignored
    cyc(1, 0, 0, 0);
    for (int i = 1; i <= 5; i++) cyc(0, 1, 1, W'(i));
    check("ovf_depth", W'(depth), 4);
    check("ovf_trap", W'(trap), 1);
    check("ovf_ready", W'(ready), 0);
    check("ovf_result", result, 4);
    cyc(0, 1, 2, 0);
    check("ovf_pop_depth", W'(depth), 4);

    // Underflow from reset, then reset clears trap
    cyc(1, 0, 0, 0);
    cyc(0, 1, 2, 0);
    check("udf_trap", W'(trap), 2);
    check("udf_empty", W'(result_empty), 1);
    cyc(1, 0, 0, 0);
    check("udf_rst_trap", W'(trap), 0);
    check("udf_rst_ready", W'(ready), 1);
    cyc(0, 1, 1, 8);
    cyc(0, 1, 4, 9);
    check("popset_udf_trap", W'(trap), 2);
    check("popset_udf_result", result, 8);

    // Illegal op at depth 2
    cyc(1, 0, 0, 0);
    cyc(0, 1, 1, 11);
    cyc(0, 1, 1, 22);
    cyc(0, 1, 5, 0);
    check("ill_trap", W'(trap), 3);
    check("ill_depth", W'(depth), 2);
    check("ill_result", result, 22);

    // CLEAR at depth 3, then reuse
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 1, W'(40 + i));
    cyc(0, 1, 7, 0);
    check("clr_depth", W'(depth), 0);
    check("clr_result", result, 0);
    check("clr_trap", W'(trap), 0);
    cyc(0, 1, 1, 32'hA5A5_0001);
    check("clr_push_result", result, 32'hA5A5_0001);
    check("clr_push_second", second, 0);

    // Reset dominates a simultaneous PUSH
    cyc(0, 1, 1, 3);
    cyc(1, 1, 1, 32'hFFFF_FFFF);
    check("rstpush_depth", W'(depth), 0);
    check("rstpush_empty", W'(result_empty), 1);
    check("rstpush_result", result, 0);

    cyc(0, 0, 0, 0);
    checking = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/operand_stack.md
OPERAND_STACK -- requirements
Module: operand_stack

Interface
REQ-001 SHALL have parameter WIDTH, default 64, data word width (covers i32 and i64 values).
REQ-002 SHALL have parameter DEPTH, default 16, maximum entry count; power of two, at least 2.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port op, input, 3, operation code as listed in REQ-012.
REQ-006 SHALL have port valid, input, 1, high when op/din are presented.
REQ-007 SHALL have port ready, output, 1, high when an op can be accepted.
REQ-008 SHALL have port din, input, WIDTH, operand for push/replace ops.
REQ-009 SHALL have port result, output, WIDTH, registered top-of-stack value.
REQ-010 SHALL have port result_empty, output, 1, high when depth is 0.
REQ-011 SHALL have ports second (output, WIDTH, registered entry below top), depth (output, clog2(DEPTH)+1, entry count) and trap (output, 3, sticky trap code).

Function
REQ-012 SHALL decode op as: NOP=0, PUSH=1, POP=2, SET_TOP=3 (replace top with din, unary result such as eqz), POP_SET=4 (drop top, replace new top with din, binary result), CLEAR=7; codes 5 and 6 are illegal.
REQ-013 SHALL accept an op only on a rising edge with valid && ready; otherwise all state holds.
REQ-014 SHALL drive ready = (trap == 0) combinationally from the registered trap.
REQ-015 SHALL update result, second, depth, result_empty one cycle after acceptance (latency 1, throughput 1 op/cycle).
REQ-016 SHALL drive result = 0 when depth == 0 and second = 0 when depth < 2.
REQ-017 PUSH at depth == DEPTH SHALL leave the stack unchanged and set trap = 1 (overflow).
REQ-018 POP or SET_TOP at depth == 0, and POP_SET at depth < 2, SHALL leave the stack unchanged and set trap = 2 (underflow).
REQ-019 An illegal op code SHALL leave the stack unchanged and set trap = 3 (illegal op).
REQ-020 CLEAR SHALL set depth to 0 from any depth without trapping.
REQ-021 trap SHALL be sticky: once nonzero, ready is low and no op is accepted until reset.
REQ-022 Pointer arithmetic SHALL never wrap: depth stays within 0..DEPTH at all times.
REQ-023 PUSH followed immediately by POP_SET or SET_TOP in the next cycle SHALL see the pushed value as top, with no bubble.

Reset
REQ-024 On reset high at a rising edge, the block SHALL set depth=0, result=0, second=0, result_empty=1 and trap=0; ready is therefore 1.
REQ-025 Reset SHALL dominate any simultaneously presented op, which is discarded.
REQ-026 Stored entry contents need not be cleared by reset.

Structure
REQ-027 Op codes and trap codes (NONE=0, OVERFLOW=1, UNDERFLOW=2, ILLEGAL=3) SHALL live in a shared package reused by the cpu.
REQ-028 Entry storage SHALL be one sub-module, stack_mem (DEPTH x WIDTH register array, one write port, two read ports at addresses top and top-1); top/second output registers remain in operand_stack.

Verification
REQ-029 Reset, PUSH 0, SET_TOP 1 -> result=1, result_empty=0, depth=1, trap=0 (eqz case).
REQ-030 PUSH 5, PUSH 7, POP_SET 12 -> result=12, depth=1, second=0.
REQ-031 DEPTH=4: five PUSHes -> depth=4, trap=1, ready=0; a following POP is ignored, and depth stays 4.
REQ-032 From reset, POP -> trap=2, result_empty=1; then reset -> trap=0, ready=1.
REQ-033 Op 5 at depth 2 -> trap=3 with depth still 2; CLEAR in a separate run at depth 3 -> depth=0, result=0.
REQ-034 WIDTH=32: PUSH 0xFFFFFFFF with reset high on the same edge -> depth=0, result_empty=1.
